logic_unit_pipe: RTL

//  Parametrised, pipelined bitwise logic unit; the registered, multi-bit successor of the

---
 rtl/logic_unit_if.sv | 32 +++
 rtl/logic_unit_pipe.sv | 109 ++++++++++
 2 files changed

// File: rtl/logic_unit_if.sv
// Operand/result bus of the pipelined logic unit.
//   in_valid/in_ready   : operand handshake (transfer when both high)
//   in_a/in_b/in_op     : operands and op code (0 AND .. 7 PASS)
//   out_valid/out_ready : result handshake (transfer when both high)
//   out_y/out_op        : result and the op code that produced it
//   out_zero/out_parity : result == 0, XOR-reduction of result
// master = operand issuer / result consumer, slave = the logic unit.
interface logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [2:0]       out_op;
  logic             out_zero;
  logic             out_parity;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_op, out_zero, out_parity
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_y, out_op, out_zero, out_parity
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit (AND, OR, NOT, NAND, NOR, XOR, XNOR, PASS).
// The result and its zero/parity flags are computed once from the operands and
// carried through STAGES register stages under valid/ready flow control.
// Outputs come straight from the last stage registers.
//   clk      : clock, all state on the rising edge
//   rst      : asynchronous active-high reset, clears every stage and the counter
//   bus      : logic_unit_if slave (operand side in_*, result side out_*)
//   op_count : number of output handshakes since reset, wraps at 2^CNT_W
module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  logic_unit_if.slave      bus,
  output logic [CNT_W-1:0] op_count
);

  if (STAGES < 1 || STAGES > 4 || WIDTH < 1) begin : g_bad_params
    $error("logic_unit_pipe: STAGES must be 1..4 and WIDTH >= 1");
  end

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [2:0]       op;
    logic             zero;
    logic             parity;
  } stage_t;

  stage_t            in_res;
  stage_t            stg_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] rdy;

  // Result and flags are formed here only; later stages just move them.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    in_res = '0;
    case (op_e'(bus.in_op))
      OP_AND:  in_res.y = bus.in_a & bus.in_b;
      OP_OR:   in_res.y = bus.in_a | bus.in_b;
      OP_NOT:  in_res.y = ~bus.in_a;
      OP_NAND: in_res.y = ~(bus.in_a & bus.in_b);
      OP_NOR:  in_res.y = ~(bus.in_a | bus.in_b);
      OP_XOR:  in_res.y = bus.in_a ^ bus.in_b;
      OP_XNOR: in_res.y = ~(bus.in_a ^ bus.in_b);
      OP_PASS: in_res.y = bus.in_a;
      default: in_res.y = '0;
    endcase
    in_res.op     = bus.in_op;
    in_res.zero   = ~|in_res.y;
    in_res.parity = ^in_res.y;
  end

  // Stage k may advance when it is empty or some stage below it (or the
  // consumer) can move: the unrolled form of ready_k = ~valid_k | ready_k+1,
  // written per stage so the chain has no self-referencing vector.
  for (genvar k = 0; k < STAGES; k++) begin : g_rdy
    assign rdy[k] = bus.out_ready | ~(&vld_q[STAGES-1:k]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the stage registers are reset too, so out_y/out_op/flags read 0 until the first result.
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage sample its upstream's old value on the same edge.
      if (rdy[0]) begin
        vld_q[0] <= bus.in_valid;
        stg_q[0] <= in_res;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_q[k] <= vld_q[k-1];
          stg_q[k] <= stg_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      op_count <= op_count + 1'b1;
    end
  end

  assign bus.in_ready   = rdy[0];
  assign bus.out_valid  = vld_q[STAGES-1];
  assign bus.out_y      = stg_q[STAGES-1].y;
  assign bus.out_op     = stg_q[STAGES-1].op;
  assign bus.out_zero   = stg_q[STAGES-1].zero;
  assign bus.out_parity = stg_q[STAGES-1].parity;

endmodule
